// File: rtl/wb_data_master_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_data_master_pkg
// Description : Shared encodings for the Wishbone data-side master and the
//               matching big-endian block-RAM responder.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_data_master_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam logic [1:0] CAUSE_NONE     = 2'd0;
    localparam logic [1:0] CAUSE_MISALIGN = 2'd1;
    localparam logic [1:0] CAUSE_BUSERR   = 2'd2;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'd3;

    localparam logic [3:0] SEL_B = 4'h1;
    localparam logic [3:0] SEL_H = 4'h3;
    localparam logic [3:0] SEL_W = 4'hf;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Size 3 is reported as misaligned so it shares the no-bus-cycle path.
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] addr_lo);
        case (size)
            SZ_BYTE: is_misaligned = 1'b0;
            SZ_HALF: is_misaligned = addr_lo[0];
            SZ_WORD: is_misaligned = (addr_lo != 2'b00);
            default: is_misaligned = 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] size_to_sel(input logic [1:0] size);
        case (size)
            SZ_BYTE: size_to_sel = SEL_B;
            SZ_HALF: size_to_sel = SEL_H;
            SZ_WORD: size_to_sel = SEL_W;
            default: size_to_sel = 4'h0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_lane_fmt.sv
`default_nettype none
// ============================================================================
// Module      : wb_lane_fmt
// Description : Combinational store-data replication and load-data
//               extract/sign-extend for size-coded Wishbone transfers.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_lane_fmt
    import wb_data_master_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] bus_rdata,
    output logic [31:0] bus_wdata,
    output logic [31:0] load_data
);

    logic w_sign_b;
    logic w_sign_h;

    assign w_sign_b = ~is_unsigned & bus_rdata[7];
    assign w_sign_h = ~is_unsigned & bus_rdata[15];

    always_comb begin
        bus_wdata = 32'h0;
        load_data = 32'h0;
        case (size)
            SZ_BYTE: begin
                bus_wdata = {4{wdata[7:0]}};
                load_data = {{24{w_sign_b}}, bus_rdata[7:0]};
            end
            SZ_HALF: begin
                bus_wdata = {2{wdata[15:0]}};
                load_data = {{16{w_sign_h}}, bus_rdata[15:0]};
            end
            SZ_WORD: begin
                bus_wdata = wdata;
                load_data = bus_rdata;
            end
            default: begin
                bus_wdata = 32'h0;
                load_data = 32'h0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/wb_data_master.sv
`default_nettype none
// ============================================================================
// Module      : wb_data_master
// Description : Wishbone classic initiator turning core load/store requests
//               into single bus cycles with a one-cycle response pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_data_master
    import wb_data_master_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [1:0]        resp_cause,
    output logic [ADDR_W-1:0] wbm_addr_o,
    output logic [31:0]       wbm_dat_o,
    output logic [3:0]        wbm_sel_o,
    output logic              wbm_cyc_o,
    output logic              wbm_stb_o,
    output logic              wbm_we_o,
    input  logic [31:0]       wbm_dat_i,
    input  logic              wbm_ack_i,
    input  logic              wbm_err_i
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_accept;
    logic              w_misaligned;
    logic              w_tmo_hit;
    logic              w_in_bus;

    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdat;
    logic [3:0]        r_sel;
    logic              r_we;
    logic [1:0]        r_size;
    logic              r_unsigned;
    logic [1:0]        r_cause;
    logic [31:0]       r_rdata;

    logic [1:0]        w_fmt_size;
    logic [31:0]       w_fmt_wdata;
    logic [31:0]       w_fmt_rdata;

    assign w_misaligned = is_misaligned(req_size, req_addr[1:0]);
    assign w_in_bus     = (r_state == ST_BUS);

    // One formatter serves both directions: store data is formatted while
    // idle from the live request, load data while the cycle is on the bus.
    assign w_fmt_size = (r_state == ST_IDLE) ? req_size : r_size;

    wb_lane_fmt u_lane_fmt (
        .size        (w_fmt_size),
        .is_unsigned (r_unsigned),
        .wdata       (req_wdata),
        .bus_rdata   (wbm_dat_i),
        .bus_wdata   (w_fmt_wdata),
        .load_data   (w_fmt_rdata)
    );

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_timeout
            localparam int c_cnt_w = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
            localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT_CYCLES - 1);
            logic [c_cnt_w-1:0] r_tmo_cnt;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_tmo_cnt <= '0;
                end else if (!w_in_bus) begin
                    r_tmo_cnt <= '0;
                end else begin
                    r_tmo_cnt <= r_tmo_cnt + 1'b1;
                end
            end

            assign w_tmo_hit = w_in_bus && (r_tmo_cnt == c_cnt_last);
        end else begin : g_no_timeout
            assign w_tmo_hit = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        req_ready   = 1'b0;
        wbm_cyc_o   = 1'b0;
        wbm_stb_o   = 1'b0;
        resp_valid  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = w_misaligned ? ST_RESP : ST_BUS;
                end
            end
            ST_BUS: begin
                wbm_cyc_o = 1'b1;
                wbm_stb_o = 1'b1;
                if (wbm_ack_i || wbm_err_i || w_tmo_hit) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                resp_valid  = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Bus-side fields only change on acceptance, so they stay put for the
    // whole cycle; the cause/data are resolved on the terminating edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr     <= '0;
            r_wdat     <= '0;
            r_sel      <= '0;
            r_we       <= 1'b0;
            r_size     <= SZ_BYTE;
            r_unsigned <= 1'b0;
            r_cause    <= CAUSE_NONE;
            r_rdata    <= '0;
        end else if (w_accept) begin
            r_addr     <= req_addr;
            r_wdat     <= w_fmt_wdata;
            r_sel      <= size_to_sel(req_size);
            r_we       <= req_we;
            r_size     <= req_size;
            r_unsigned <= req_unsigned;
            r_cause    <= w_misaligned ? CAUSE_MISALIGN : CAUSE_NONE;
            r_rdata    <= '0;
        end else if (w_in_bus) begin
            if (wbm_err_i) begin
                r_cause <= CAUSE_BUSERR;
            end else if (wbm_ack_i) begin
                if (!r_we) begin
                    r_rdata <= w_fmt_rdata;
                end
            end else if (w_tmo_hit) begin
                r_cause <= CAUSE_TIMEOUT;
            end
        end
    end

    assign wbm_addr_o = r_addr;
    assign wbm_dat_o  = r_wdat;
    assign wbm_sel_o  = r_sel;
    assign wbm_we_o   = r_we & w_in_bus;

    assign resp_err   = resp_valid && (r_cause != CAUSE_NONE);
    assign resp_cause = resp_valid ? r_cause : CAUSE_NONE;
    assign resp_rdata = resp_valid ? r_rdata : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_wb_data_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_data_master
// Description : Directed self-checking bench for wb_data_master.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_wb_data_master;

    localparam int TMO = 8;
    localparam int RM_NORMAL  = 0;
    localparam int RM_SILENT  = 1;
    localparam int RM_ERR_ACK = 2;
    localparam int RM_ERR     = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [1:0]  resp_cause;
    logic [31:0] wbm_addr_o;
    logic [31:0] wbm_dat_o;
    logic [3:0]  wbm_sel_o;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [31:0] wbm_dat_i = 32'h0;
    logic        wbm_ack_i = 1'b0;
    logic        wbm_err_i = 1'b0;

    always #5 clk = ~clk;

    wb_data_master #(.TIMEOUT_CYCLES(TMO), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .resp_cause(resp_cause),
        .wbm_addr_o(wbm_addr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
        .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i)
    );

    int checks = 0;
    int errors = 0;

    // Responder: byte memory; read data right-aligned, upper lanes filled
    // with a marker so extension bugs show up.
    logic [7:0] mem [0:63];
    int rsp_mode  = RM_NORMAL;
    int rsp_delay = 0;
    int rsp_wait  = 0;

    always @(negedge clk) begin
        if (wbm_ack_i || wbm_err_i) begin
            wbm_ack_i = 1'b0;
            wbm_err_i = 1'b0;
            wbm_dat_i = 32'h0;
            rsp_wait  = 0;
        end else if (!wbm_cyc_o) begin
            rsp_wait = 0;
        end else if (wbm_stb_o && rsp_mode != RM_SILENT) begin
            if (rsp_wait < rsp_delay) begin
                rsp_wait++;
            end else begin
                int a;
                a = int'(wbm_addr_o[5:0]);
                if (wbm_we_o && rsp_mode == RM_NORMAL) begin
                    case (wbm_sel_o)
                        4'hf: begin
                            mem[a] = wbm_dat_o[31:24]; mem[(a+1)%64] = wbm_dat_o[23:16];
                            mem[(a+2)%64] = wbm_dat_o[15:8]; mem[(a+3)%64] = wbm_dat_o[7:0];
                        end
                        4'h3: begin mem[a] = wbm_dat_o[15:8]; mem[(a+1)%64] = wbm_dat_o[7:0]; end
                        4'h1: mem[a] = wbm_dat_o[7:0];
                        default: ;
                    endcase
                end
                case (wbm_sel_o)
                    4'hf: wbm_dat_i = {mem[a], mem[(a+1)%64], mem[(a+2)%64], mem[(a+3)%64]};
                    4'h3: wbm_dat_i = {16'h5C5C, mem[a], mem[(a+1)%64]};
                    default: wbm_dat_i = {24'hC3C3C3, mem[a]};
                endcase
                wbm_ack_i = (rsp_mode == RM_NORMAL) || (rsp_mode == RM_ERR_ACK);
                wbm_err_i = (rsp_mode == RM_ERR_ACK) || (rsp_mode == RM_ERR);
            end
        end
    end

    // Results of the last transaction.
    logic [31:0] t_rdata, t_dat_o, t_addr;
    logic        t_err, t_we, t_ready, t_pulse_ok;
    logic [1:0]  t_cause;
    logic [3:0]  t_sel;
    int          t_lat, t_cyc;

    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata);
        @(negedge clk);
        t_ready      = req_ready;
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        t_lat = 0; t_cyc = 0; t_rdata = '0; t_err = 1'b0; t_cause = '0;
        t_sel = '0; t_dat_o = '0; t_we = 1'b0; t_addr = '0; t_pulse_ok = 1'b0;
        while (t_lat < 40) begin
            @(negedge clk);
            #1;
            t_lat++;
            if (wbm_cyc_o) begin
                t_cyc++;
                if (t_cyc == 1) begin
                    t_sel = wbm_sel_o; t_dat_o = wbm_dat_o; t_we = wbm_we_o; t_addr = wbm_addr_o;
                end
            end
            if (resp_valid) begin
                t_rdata = resp_rdata; t_err = resp_err; t_cause = resp_cause;
                break;
            end
        end
        if (resp_valid) begin
            @(negedge clk);
            #1;
            t_pulse_ok = !resp_valid && req_ready && !wbm_cyc_o;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({wbm_cyc_o, wbm_stb_o, wbm_we_o, resp_valid, resp_err} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b exp 00000", {wbm_cyc_o, wbm_stb_o, wbm_we_o, resp_valid, resp_err});
        end
        checks++;
        if ({wbm_sel_o, wbm_addr_o, wbm_dat_o, resp_rdata, resp_cause} !== 102'h0) begin
            errors++;
            $display("FAIL reset_data got sel %h addr %h dat %h rdata %h cause %0d exp all 0",
                     wbm_sel_o, wbm_addr_o, wbm_dat_o, resp_rdata, resp_cause);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", req_ready); end
    endtask

    task automatic test_word();
        do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'h80028293);
        checks++;
        if (t_ready !== 1'b1) begin errors++; $display("FAIL word_st_ready got %b exp 1", t_ready); end
        checks++;
        if ({t_sel, t_we, t_dat_o, t_addr} !== {4'hf, 1'b1, 32'h80028293, 32'h10}) begin
            errors++;
            $display("FAIL word_st_bus got sel %h we %b dat %h addr %h exp f 1 80028293 10", t_sel, t_we, t_dat_o, t_addr);
        end
        checks++;
        if ({t_lat, t_cyc, t_err, t_cause, t_rdata, t_pulse_ok} !== {32'd2, 32'd1, 1'b0, 2'd0, 32'h0, 1'b1}) begin
            errors++;
            $display("FAIL word_st_resp got lat %0d cyc %0d err %b cause %0d rdata %h pulse %b exp 2 1 0 0 0 1",
                     t_lat, t_cyc, t_err, t_cause, t_rdata, t_pulse_ok);
        end
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF);
        checks++;
        if ({t_rdata, t_err, t_sel, t_we} !== {32'h80028293, 1'b0, 4'hf, 1'b0}) begin
            errors++;
            $display("FAIL word_ld got rdata %h err %b sel %h we %b exp 80028293 0 f 0", t_rdata, t_err, t_sel, t_we);
        end
    endtask

    task automatic test_byte();
        mem[4] = 8'hF0;
        do_req(1'b0, 2'd0, 1'b0, 32'h4, 32'h0);
        checks++;
        if ({t_rdata, t_sel, t_err} !== {32'hFFFFFFF0, 4'h1, 1'b0}) begin
            errors++;
            $display("FAIL byte_ld_signed got rdata %h sel %h err %b exp fffffff0 1 0", t_rdata, t_sel, t_err);
        end
        do_req(1'b0, 2'd0, 1'b1, 32'h4, 32'h0);
        checks++;
        if (t_rdata !== 32'h000000F0) begin errors++; $display("FAIL byte_ld_unsigned got %h exp 000000f0", t_rdata); end
        do_req(1'b1, 2'd0, 1'b0, 32'h3, 32'h123456A5);
        checks++;
        if ({t_dat_o, t_sel, t_we} !== {32'hA5A5A5A5, 4'h1, 1'b1}) begin
            errors++;
            $display("FAIL byte_st got dat %h sel %h we %b exp a5a5a5a5 1 1", t_dat_o, t_sel, t_we);
        end
    endtask

    task automatic test_half();
        do_req(1'b1, 2'd1, 1'b0, 32'h8, 32'h1234BEEF);
        checks++;
        if ({t_dat_o, t_sel, t_we} !== {32'hBEEFBEEF, 4'h3, 1'b1}) begin
            errors++;
            $display("FAIL half_st got dat %h sel %h we %b exp beefbeef 3 1", t_dat_o, t_sel, t_we);
        end
        do_req(1'b0, 2'd1, 1'b0, 32'h8, 32'h0);
        checks++;
        if (t_rdata !== 32'hFFFFBEEF) begin errors++; $display("FAIL half_ld_signed got %h exp ffffbeef", t_rdata); end
        do_req(1'b0, 2'd1, 1'b1, 32'h8, 32'h0);
        checks++;
        if (t_rdata !== 32'h0000BEEF) begin errors++; $display("FAIL half_ld_unsigned got %h exp 0000beef", t_rdata); end
    endtask

    task automatic test_misalign();
        logic [1:0]  sz [3] = '{2'd2, 2'd3, 2'd1};
        logic [31:0] ad [3] = '{32'h6, 32'h0, 32'h5};
        for (int i = 0; i < 3; i++) begin
            do_req(1'b0, sz[i], 1'b0, ad[i], 32'h0);
            checks++;
            if ({t_lat, t_cyc, t_err, t_cause, t_rdata, t_pulse_ok} !== {32'd1, 32'd0, 1'b1, 2'd1, 32'h0, 1'b1}) begin
                errors++;
                $display("FAIL misalign_%0d got lat %0d cyc %0d err %b cause %0d rdata %h pulse %b exp 1 0 1 1 0 1",
                         i, t_lat, t_cyc, t_err, t_cause, t_rdata, t_pulse_ok);
            end
        end
    endtask

    task automatic test_latency();
        rsp_delay = 3;
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        rsp_delay = 0;
        checks++;
        if ({t_lat, t_cyc, t_rdata} !== {32'd5, 32'd4, 32'h80028293}) begin
            errors++;
            $display("FAIL wait_states got lat %0d cyc %0d rdata %h exp 5 4 80028293", t_lat, t_cyc, t_rdata);
        end
    endtask

    task automatic test_timeout();
        rsp_mode = RM_SILENT;
        do_req(1'b1, 2'd2, 1'b0, 32'h20, 32'h11223344);
        rsp_mode = RM_NORMAL;
        checks++;
        if ({t_lat, t_cyc, t_err, t_cause, t_pulse_ok} !== {32'd9, 32'd8, 1'b1, 2'd3, 1'b1}) begin
            errors++;
            $display("FAIL timeout got lat %0d cyc %0d err %b cause %0d pulse %b exp 9 8 1 3 1",
                     t_lat, t_cyc, t_err, t_cause, t_pulse_ok);
        end
    endtask

    task automatic test_bus_err();
        rsp_mode = RM_ERR_ACK;
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        checks++;
        if ({t_lat, t_err, t_cause, t_rdata} !== {32'd2, 1'b1, 2'd2, 32'h0}) begin
            errors++;
            $display("FAIL err_with_ack got lat %0d err %b cause %0d rdata %h exp 2 1 2 0", t_lat, t_err, t_cause, t_rdata);
        end
        rsp_mode = RM_ERR;
        do_req(1'b0, 2'd0, 1'b0, 32'h4, 32'h0);
        rsp_mode = RM_NORMAL;
        checks++;
        if ({t_err, t_cause, t_rdata} !== {1'b1, 2'd2, 32'h0}) begin
            errors++;
            $display("FAIL err_only got err %b cause %0d rdata %h exp 1 2 0", t_err, t_cause, t_rdata);
        end
    endtask

    task automatic test_reset_mid_bus();
        logic seen_resp;
        rsp_mode = RM_SILENT;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h10;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (wbm_cyc_o !== 1'b1) begin errors++; $display("FAIL mid_bus_cyc_before got %b exp 1", wbm_cyc_o); end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({wbm_cyc_o, wbm_stb_o} !== 2'b00) begin
            errors++;
            $display("FAIL mid_bus_async_drop got cyc %b stb %b exp 0 0", wbm_cyc_o, wbm_stb_o);
        end
        @(negedge clk);
        rst = 1'b0;
        rsp_mode = RM_NORMAL;
        seen_resp = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (resp_valid || wbm_cyc_o) seen_resp = 1'b1;
        end
        checks++;
        if (seen_resp !== 1'b0) begin errors++; $display("FAIL mid_bus_no_resp got %b exp 0", seen_resp); end
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        checks++;
        if ({t_lat, t_err, t_rdata} !== {32'd2, 1'b0, 32'h80028293}) begin
            errors++;
            $display("FAIL after_reset_ld got lat %0d err %b rdata %h exp 2 0 80028293", t_lat, t_err, t_rdata);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 8'h00;
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_misalign();
        test_latency();
        test_timeout();
        test_bus_err();
        test_reset_mid_bus();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
